// File: rtl/stdmacro_dff_pipe_pkg.sv
// Shared helpers for the multi-stage DFF pipeline.
// Holds sizing functions used by the pipeline top level.
package stdmacro_dff_pipe_pkg;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stdmacro_dff_pipe_stage.sv
// One pipeline stage: a valid bit plus a payload register.
// The payload only loads when the incoming valid is set, so bubbles do not toggle data.
module stdmacro_dff_pipe_stage #(
    parameter int unsigned          DFF_WIDTH   = 1,
    parameter logic [DFF_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 vin,
    input  logic [DFF_WIDTH-1:0] din,
    output logic                 vout,
    output logic [DFF_WIDTH-1:0] dout
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vout <= 1'b0;
            dout <= RESET_VALUE;
        end else if (en) begin
            vout <= vin;
            if (vin) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/stdmacro_dff_pipe.sv
// Parametrised valid/ready register pipeline with optional bubble collapsing,
// synchronous flush and a registered occupancy count.
module stdmacro_dff_pipe
    import stdmacro_dff_pipe_pkg::*;
#(
    parameter int unsigned          DFF_WIDTH       = 1,
    parameter int unsigned          DFF_DEPTH       = 2,
    parameter logic [DFF_WIDTH-1:0] RESET_VALUE     = '0,
    parameter bit                   BUBBLE_COLLAPSE = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             i_valid,
    output logic                             i_ready,
    input  logic [DFF_WIDTH-1:0]             i_data,
    output logic                             o_valid,
    input  logic                             o_ready,
    output logic [DFF_WIDTH-1:0]             o_data,
    output logic [cnt_w(DFF_DEPTH)-1:0]      o_count
);

    localparam int unsigned CW   = cnt_w(DFF_DEPTH);
    localparam int unsigned LAST = DFF_DEPTH - 1;

    if (DFF_DEPTH < 1) begin : g_bad_depth
        $error("stdmacro_dff_pipe: DFF_DEPTH must be at least 1");
    end
    if (DFF_WIDTH < 1) begin : g_bad_width
        $error("stdmacro_dff_pipe: DFF_WIDTH must be at least 1");
    end

    logic [DFF_DEPTH-1:0] v;
    logic [DFF_DEPTH-1:0] adv;
    logic [DFF_DEPTH-1:0] en;
    logic [DFF_DEPTH-1:0] vin;
    logic [DFF_WIDTH-1:0] d   [DFF_DEPTH];
    logic [DFF_WIDTH-1:0] din [DFF_DEPTH];
    logic                 in_xfer;
    logic                 out_xfer;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;

    // Advance chain runs from the output back to stage 0, so o_ready reaches
    // i_ready combinationally through every stage.
    always_comb begin
        logic adv_last;
        logic chain;
        adv      = '0;
        adv_last = ~v[LAST] | o_ready;
        chain    = adv_last;
        adv[LAST] = adv_last;
        for (int k = int'(DFF_DEPTH) - 2; k >= 0; k--) begin
            chain  = BUBBLE_COLLAPSE ? (~v[k] | chain) : adv_last;
            adv[k] = chain;
        end
    end

    always_comb begin
        i_ready  = adv[0] & ~flush;
        in_xfer  = i_valid & i_ready;
        out_xfer = o_valid & o_ready;
    end

    // Flush forces every stage to load a zero valid; payloads are left as they are.
    always_comb begin
        en     = adv | {DFF_DEPTH{flush}};
        vin    = '0;
        vin[0] = in_xfer;
        din[0] = i_data;
        for (int k = 1; k < int'(DFF_DEPTH); k++) begin
            vin[k] = v[k-1] & ~flush;
            din[k] = d[k-1];
        end
    end

    for (genvar k = 0; k < DFF_DEPTH; k++) begin : g_stage
        stdmacro_dff_pipe_stage #(
            .DFF_WIDTH   (DFF_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (en[k]),
            .vin   (vin[k]),
            .din   (din[k]),
            .vout  (v[k]),
            .dout  (d[k])
        );
    end

    always_comb begin
        count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_valid = v[LAST];
    assign o_data  = d[LAST];
    assign o_count = count_q;

endmodule

// File: tb/tb_stdmacro_dff_pipe.sv
// Directed and randomized bench for stdmacro_dff_pipe (W=8, D=3), checked against
// a queue-based model of accepted items and their ages.
module tb_stdmacro_dff_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 3;
    localparam int unsigned CW = $clog2(D + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset  = 1'b1;
    logic         rst_rv = 1'b1;
    logic         flush  = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready = 1'b0;
    logic [W-1:0] i_data;

    logic a_ir, a_ov, b_ir, b_ov, r_ir, r_ov;
    logic [W-1:0]  a_od, b_od, r_od;
    logic [CW-1:0] a_cnt, b_cnt, r_cnt;

    stdmacro_dff_pipe #(.DFF_WIDTH(W), .DFF_DEPTH(D), .RESET_VALUE(8'h00),
                        .BUBBLE_COLLAPSE(1'b1)) u_bc1 (
        .clk(clk), .reset(reset), .flush(flush), .i_valid(i_valid), .i_ready(a_ir),
        .i_data(i_data), .o_valid(a_ov), .o_ready(o_ready), .o_data(a_od), .o_count(a_cnt)
    );

    stdmacro_dff_pipe #(.DFF_WIDTH(W), .DFF_DEPTH(D), .RESET_VALUE(8'h00),
                        .BUBBLE_COLLAPSE(1'b0)) u_bc0 (
        .clk(clk), .reset(reset), .flush(flush), .i_valid(i_valid), .i_ready(b_ir),
        .i_data(i_data), .o_valid(b_ov), .o_ready(o_ready), .o_data(b_od), .o_count(b_cnt)
    );

    stdmacro_dff_pipe #(.DFF_WIDTH(W), .DFF_DEPTH(D), .RESET_VALUE(8'hA5),
                        .BUBBLE_COLLAPSE(1'b1)) u_rv (
        .clk(clk), .reset(rst_rv), .flush(flush), .i_valid(i_valid), .i_ready(r_ir),
        .i_data(i_data), .o_valid(r_ov), .o_ready(o_ready), .o_data(r_od), .o_count(r_cnt)
    );

    int vectors = 0;
    int fails   = 0;

    // Model of u_bc1: accepted items in order with edges elapsed since acceptance.
    logic [W-1:0] q_data[$];
    int           q_age[$];
    logic         exp_ready;
    logic         exp_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        exp_ready = !flush && ((q_data.size() < int'(D)) || o_ready);
        exp_ov    = (q_data.size() > 0) && (q_age[0] >= int'(D));
        check("model_i_ready", a_ir, exp_ready);
        check("model_o_valid", a_ov, exp_ov);
        check("model_o_count", a_cnt, q_data.size());
        if (exp_ov) begin
            check("model_o_data", a_od, q_data[0]);
        end
    endtask

    task automatic advance();
        logic         tin;
        logic         tout;
        logic [W-1:0] tdata;
        tin   = i_valid && exp_ready;
        tout  = exp_ov && o_ready;
        tdata = i_data;
        @(posedge clk);
        if (reset) begin
            q_data.delete();
            q_age.delete();
        end else begin
            if (tout) begin
                void'(q_data.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i]++;
            if (flush) begin
                q_data.delete();
                q_age.delete();
            end
            if (tin) begin
                q_data.push_back(tdata);
                q_age.push_back(1);
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    logic [W-1:0] items [5];
    int           idx;

    initial begin
        i_data = 'x;
        items[0] = 8'h11; items[1] = 8'h22; items[2] = 8'h33;
        items[3] = 8'h44; items[4] = 8'h55;

        // Reset state, with X payload and no valid
        step();
        sample();
        check("rst_o_valid", a_ov, 1'b0);
        check("rst_o_data", a_od, 8'h00);
        check("rst_o_count", a_cnt, 0);
        check("rst_i_ready", a_ir, 1'b1);
        check("rst_rv_o_data", r_od, 8'hA5);
        advance();
        reset  = 1'b0;
        rst_rv = 1'b0;

        // Streaming with o_ready high: 3-cycle latency, one per cycle
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data = 8'h11; step();
        i_data = 8'h22; step();
        i_data = 8'h33; step();
        i_data = 8'h44;
        sample();
        check("stream_first_valid", a_ov, 1'b1);
        check("stream_first_data", a_od, 8'h11);
        check("stream_count_full", a_cnt, 3);
        advance();
        i_valid = 1'b0;
        i_data  = 'x;
        sample(); check("stream_d22", a_od, 8'h22); check("stream_count_hold", a_cnt, 3); advance();
        sample(); check("stream_d33", a_od, 8'h33); advance();
        sample(); check("stream_d44", a_od, 8'h44); advance();
        step(); step();

        // Backpressure: only three items fit
        o_ready = 1'b0;
        i_valid = 1'b1;
        idx = 0;
        for (int n = 0; n < 4; n++) begin
            i_data = items[idx];
            sample();
            if (exp_ready) idx++;
            advance();
        end
        i_data = items[idx];
        sample();
        check("bp_i_ready", a_ir, 1'b0);
        check("bp_count", a_cnt, 3);
        check("bp_head", a_od, 8'h11);
        advance();
        o_ready = 1'b1;
        i_valid = 1'b0;
        i_data  = 'x;
        sample(); check("drain_d11", a_od, 8'h11); advance();
        sample(); check("drain_d22", a_od, 8'h22); advance();
        sample(); check("drain_d33", a_od, 8'h33); advance();
        sample(); check("drain_empty", a_ov, 1'b0); check("drain_count", a_cnt, 0); advance();

        // Bubble collapse versus lock-step with one item stalled at the output
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h5A;
        step();
        i_valid = 1'b0;
        i_data  = 'x;
        step(); step();
        i_valid = 1'b1;
        i_data  = 8'hAA;
        sample();
        check("bc1_i_ready", a_ir, 1'b1);
        check("bc0_i_ready", b_ir, 1'b0);
        check("bc1_head_held", a_od, 8'h5A);
        advance();
        i_valid = 1'b0;
        i_data  = 'x;
        sample();
        check("bc1_count", a_cnt, 2);
        check("bc0_count", b_cnt, 1);
        advance();
        o_ready = 1'b1;
        repeat (5) step();

        // Flush of a full pipe with o_ready high
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 8'hC1; step();
        i_data = 8'hC2; step();
        i_data = 8'hC3; step();
        flush   = 1'b1;
        o_ready = 1'b1;
        i_data  = 8'hC4;
        sample();
        check("flush_i_ready", a_ir, 1'b0);
        check("flush_out_valid", a_ov, 1'b1);
        check("flush_out_data", a_od, 8'hC1);
        advance();
        flush   = 1'b0;
        o_ready = 1'b0;
        i_valid = 1'b0;
        sample();
        check("flush_o_valid", a_ov, 1'b0);
        check("flush_count", a_cnt, 0);
        advance();

        // Randomized traffic: a stall-heavy phase then a drain-heavy phase
        for (int n = 0; n < 600; n++) begin
            i_valid = ($urandom % 4) != 0;
            i_data  = W'($urandom);
            o_ready = (n < 300) ? (($urandom % 3) == 0) : (($urandom % 4) != 0);
            flush   = ($urandom % 40) == 0;
            step();
        end

        // Asynchronous reset between edges on the RESET_VALUE=A5 instance
        flush   = 1'b1;
        i_valid = 1'b0;
        step();
        flush   = 1'b0;
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = W'($urandom);
        repeat (3) step();
        i_valid = 1'b0;
        sample();
        check("rv_pre_o_valid", r_ov, 1'b1);
        #2 rst_rv = 1'b1;
        #1;
        check("rv_async_o_valid", r_ov, 1'b0);
        check("rv_async_o_data", r_od, 8'hA5);
        check("rv_async_count", r_cnt, 0);
        advance();
        rst_rv = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
